// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg timer: FSM encoding, BCD digit width,
// display limits and the MM:SS time record.
package egg_timer_pkg;

  localparam int DIGIT_W = 4;
  localparam int MAX_MIN = 99;
  localparam int MAX_SEC = 59;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_ALARM = 2'd3;

  typedef struct packed {
    logic [DIGIT_W-1:0] min_tens;
    logic [DIGIT_W-1:0] min_ones;
    logic [DIGIT_W-1:0] sec_tens;
    logic [DIGIT_W-1:0] sec_ones;
  } bcd_time_t;

  localparam bcd_time_t TIME_ZERO = bcd_time_t'(16'h0000);

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for one asynchronous input followed by a
// rising-edge detector that yields a single-cycle strobe.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic strobe
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // Shift the input through the synchronizer and remember the previous synchronized level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], async_in};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign level  = sync_r[SYNC_STAGES-1];
  assign strobe = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer controller: preset entry, BCD countdown, pause and a timed
// alarm phase, all clocked from the single system clock.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int ALARM_SECONDS = 30
) (
  input  logic         CLK100Mhz,
  input  logic         reset_n,
  input  logic         pulse_1Hz,
  input  logic         pulse_500Hz,
  input  logic         btn_start,
  input  logic         btn_stop,
  input  logic         btn_min,
  input  logic         btn_sec,
  output logic [3:0]   min_tens,
  output logic [3:0]   min_ones,
  output logic [3:0]   sec_tens,
  output logic [3:0]   sec_ones,
  output logic         running,
  output logic         alarm,
  output logic         buzzer
);

  logic tick, start_s, stop_s, min_s, sec_s, tone_s;
  logic tick_lvl_s, start_lvl_s, stop_lvl_s, min_lvl_s, sec_lvl_s, tone_strobe_s;
  logic unused_s;

  logic [1:0]  state_r, state_nx_s;
  bcd_time_t   preset_r, preset_nx_s;
  bcd_time_t   count_r, count_nx_s;
  bcd_time_t   disp_r, disp_nx_s;
  logic [15:0] alarm_cnt_r, alarm_cnt_nx_s;
  logic        running_r, alarm_r, buzzer_r;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tick  (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(pulse_1Hz),   .level(tick_lvl_s),  .strobe(tick));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_tone  (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(pulse_500Hz), .level(tone_s),      .strobe(tone_strobe_s));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_start (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(btn_start),   .level(start_lvl_s), .strobe(start_s));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_stop  (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(btn_stop),    .level(stop_lvl_s),  .strobe(stop_s));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_min   (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(btn_min),     .level(min_lvl_s),   .strobe(min_s));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sec   (.clk(CLK100Mhz), .rst_n(reset_n), .async_in(btn_sec),     .level(sec_lvl_s),   .strobe(sec_s));

  assign unused_s = ^{tick_lvl_s, start_lvl_s, stop_lvl_s, min_lvl_s, sec_lvl_s, tone_strobe_s};

  function automatic bcd_time_t inc_minutes(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.min_tens == 4'(MAX_MIN / 10) && t.min_ones == 4'(MAX_MIN % 10)) begin
      r.min_tens = 4'd0;
      r.min_ones = 4'd0;
    end else if (t.min_ones == 4'd9) begin
      r.min_ones = 4'd0;
      r.min_tens = t.min_tens + 4'd1;
    end else begin
      r.min_ones = t.min_ones + 4'd1;
    end
    return r;
  endfunction

  // Seconds wrap on their own; the minutes field is never touched here
  function automatic bcd_time_t inc_seconds(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_tens == 4'(MAX_SEC / 10) && t.sec_ones == 4'(MAX_SEC % 10)) begin
      r.sec_tens = 4'd0;
      r.sec_ones = 4'd0;
    end else if (t.sec_ones == 4'd9) begin
      r.sec_ones = 4'd0;
      r.sec_tens = t.sec_tens + 4'd1;
    end else begin
      r.sec_ones = t.sec_ones + 4'd1;
    end
    return r;
  endfunction

  // Caller guarantees t is nonzero, so the minute borrow never underflows
  function automatic bcd_time_t dec_time(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else if (t.sec_tens != 4'd0) begin
      r.sec_tens = t.sec_tens - 4'd1;
      r.sec_ones = 4'd9;
    end else begin
      r.sec_tens = 4'(MAX_SEC / 10);
      r.sec_ones = 4'(MAX_SEC % 10);
      if (t.min_ones != 4'd0) begin
        r.min_ones = t.min_ones - 4'd1;
      end else begin
        r.min_ones = 4'd9;
        r.min_tens = t.min_tens - 4'd1;
      end
    end
    return r;
  endfunction

  // Next-state, preset/count update and alarm-phase timing
  always_comb begin
    state_nx_s     = state_r;
    preset_nx_s    = preset_r;
    count_nx_s     = count_r;
    alarm_cnt_nx_s = alarm_cnt_r;
    case (state_r)
      ST_IDLE: begin
        preset_nx_s = min_s ? inc_minutes(preset_r) : preset_r;
        preset_nx_s = sec_s ? inc_seconds(preset_nx_s) : preset_nx_s;
        if (start_s && !stop_s && (preset_r != TIME_ZERO)) begin
          count_nx_s = preset_r;
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop_s) begin
          state_nx_s = ST_PAUSE;
        end else if (count_r == TIME_ZERO) begin
          state_nx_s     = ST_ALARM;
          alarm_cnt_nx_s = 16'd0;
        end else if (tick) begin
          count_nx_s = dec_time(count_r);
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (stop_s) begin
          state_nx_s = ST_IDLE;
        end else if (start_s) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (start_s || stop_s) begin
          state_nx_s = ST_IDLE;
        end else if (tick) begin
          if (alarm_cnt_r == 16'(ALARM_SECONDS - 1)) begin
            state_nx_s     = ST_IDLE;
            alarm_cnt_nx_s = 16'd0;
          end else begin
            alarm_cnt_nx_s = alarm_cnt_r + 16'd1;
          end
        end else begin
          state_nx_s = ST_ALARM;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Display source follows the state being entered so outputs track it in the same edge
  always_comb begin
    disp_nx_s = TIME_ZERO;
    case (state_nx_s)
      ST_IDLE:  disp_nx_s = preset_nx_s;
      ST_RUN:   disp_nx_s = count_nx_s;
      ST_PAUSE: disp_nx_s = count_nx_s;
      ST_ALARM: disp_nx_s = TIME_ZERO;
      default:  disp_nx_s = TIME_ZERO;
    endcase
  end

  // State, time registers and registered outputs
  always_ff @(posedge CLK100Mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      preset_r    <= TIME_ZERO;
      count_r     <= TIME_ZERO;
      alarm_cnt_r <= 16'd0;
      disp_r      <= TIME_ZERO;
      running_r   <= 1'b0;
      alarm_r     <= 1'b0;
      buzzer_r    <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      preset_r    <= preset_nx_s;
      count_r     <= count_nx_s;
      alarm_cnt_r <= alarm_cnt_nx_s;
      disp_r      <= disp_nx_s;
      running_r   <= (state_nx_s == ST_RUN);
      alarm_r     <= (state_nx_s == ST_ALARM);
      buzzer_r    <= (state_nx_s == ST_ALARM) & tone_s;
    end
  end

  assign min_tens = disp_r.min_tens;
  assign min_ones = disp_r.min_ones;
  assign sec_tens = disp_r.sec_tens;
  assign sec_ones = disp_r.sec_ones;
  assign running  = running_r;
  assign alarm    = alarm_r;
  assign buzzer   = buzzer_r;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// Self-checking bench for egg_timer_ctrl: directed scenarios plus random
// button/tick sequences, checked against a seconds-based reference model.
module tb_egg_timer_ctrl;

  localparam int SYNC    = 2;
  localparam int ALARM_S = 30;
  localparam int HOLD    = 4;
  localparam int SETTLE  = 6;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pulse_1Hz, pulse_500Hz, btn_start, btn_stop, btn_min, btn_sec;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm, buzzer;

  int n_cmp = 0;
  int n_err = 0;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_ALARM} mstate_t;
  mstate_t m_state;
  int      m_pmin, m_psec, m_count, m_acnt;
  bit      m_tone;

  always #5 clk = ~clk;

  egg_timer_ctrl #(.SYNC_STAGES(SYNC), .ALARM_SECONDS(ALARM_S)) dut (
    .CLK100Mhz(clk), .reset_n(reset_n), .pulse_1Hz(pulse_1Hz), .pulse_500Hz(pulse_500Hz),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_min(btn_min), .btn_sec(btn_sec),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .alarm(alarm), .buzzer(buzzer)
  );

  function automatic logic [18:0] observed();
    return {min_tens, min_ones, sec_tens, sec_ones, running, alarm, buzzer};
  endfunction

  function automatic logic [18:0] expected();
    int dm, ds;
    dm = 0;
    ds = 0;
    case (m_state)
      M_IDLE:         begin dm = m_pmin;       ds = m_psec;       end
      M_RUN, M_PAUSE: begin dm = m_count / 60; ds = m_count % 60; end
      default:        begin dm = 0;            ds = 0;            end
    endcase
    return {4'(dm / 10), 4'(dm % 10), 4'(ds / 10), 4'(ds % 10),
            m_state == M_RUN, m_state == M_ALARM, (m_state == M_ALARM) && m_tone};
  endfunction

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (digits,run,alarm,buzz)", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check(tag, observed(), expected());
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pmin  = 0;
    m_psec  = 0;
    m_count = 0;
    m_acnt  = 0;
  endtask

  task automatic model_apply(input bit st, input bit sp, input bit mn, input bit sc, input bit tk);
    int old;
    case (m_state)
      M_IDLE: begin
        old = m_pmin * 60 + m_psec;
        if (mn) m_pmin = (m_pmin + 1) % 100;
        if (sc) m_psec = (m_psec + 1) % 60;
        if (st && !sp && old != 0) begin
          m_count = old;
          m_state = M_RUN;
        end
      end
      M_RUN: begin
        if (sp) m_state = M_PAUSE;
        else if (tk) begin
          m_count--;
          if (m_count == 0) begin
            m_state = M_ALARM;
            m_acnt  = 0;
          end
        end
      end
      M_PAUSE: begin
        if (sp) m_state = M_IDLE;
        else if (st) m_state = M_RUN;
      end
      default: begin
        if (st || sp) m_state = M_IDLE;
        else if (tk) begin
          m_acnt++;
          if (m_acnt == ALARM_S) m_state = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic act(input string tag, input bit st, input bit sp, input bit mn, input bit sc, input bit tk);
    @(negedge clk);
    btn_start = st; btn_stop = sp; btn_min = mn; btn_sec = sc; pulse_1Hz = tk;
    repeat (HOLD) @(negedge clk);
    btn_start = 1'b0; btn_stop = 1'b0; btn_min = 1'b0; btn_sec = 1'b0; pulse_1Hz = 1'b0;
    repeat (SETTLE) @(negedge clk);
    model_apply(st, sp, mn, sc, tk);
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("reset_async", observed(), 19'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (SETTLE) @(negedge clk);
    check_state("reset_release");
  endtask

  task automatic tone(input bit v);
    @(negedge clk);
    pulse_500Hz = v;
    repeat (SYNC + 2) @(negedge clk);
    m_tone = v;
    check_state("buzzer_follow");
  endtask

  task automatic tick_latency();
    @(negedge clk);
    pulse_1Hz = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    model_apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_state("tick_latency");
    pulse_1Hz = 1'b0;
    repeat (SETTLE) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; pulse_1Hz = 1'b0; pulse_500Hz = 1'b0;
    btn_start = 1'b0; btn_stop = 1'b0; btn_min = 1'b0; btn_sec = 1'b0;
    m_tone = 1'b0;
    model_reset();

    // Basic preset entry and countdown, including pin-to-display latency
    do_reset();
    repeat (3) act("preset_min", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (5) act("preset_sec", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act("start_0305", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick_latency();
    repeat (4) act("count_to_0300", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Expiry, buzzer gating and automatic return after the alarm period
    do_reset();
    repeat (2) act("preset_0002", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act("start_0002", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) act("expire", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tone(1'b1);
    tone(1'b0);
    tone(1'b1);
    repeat (ALARM_S) act("alarm_timeout", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tone(1'b0);

    // Pause holds the count; ticks ignored while paused
    do_reset();
    act("preset_0100", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    act("start_0100", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    act("tick_0059", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    act("pause", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) act("pause_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    act("resume", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    act("tick_0058", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    act("pause2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    act("pause_to_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Preset wrap at 99:59 and start refused at 00:00
    do_reset();
    repeat (59) act("set_min_sec", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (40) act("set_min", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    act("wrap_min", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    act("wrap_sec", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act("start_zero_ignored", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Stop beats a simultaneous tick
    do_reset();
    repeat (10) act("preset_0010", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    act("start_0010", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    act("stop_and_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    act("stop_to_idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset mid-countdown with start held high
    act("restart_0010", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) act("count_to_0007", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    btn_start = 1'b1;
    reset_n   = 1'b0;
    #1;
    check("reset_mid_run", observed(), 19'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    repeat (10) @(negedge clk);
    check_state("reset_start_held");
    btn_start = 1'b0;
    repeat (SETTLE) @(negedge clk);
    check_state("reset_start_released");

    // Random mixes of buttons and ticks
    do_reset();
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: act("rnd_tick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        3:       act("rnd_start", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        4:       act("rnd_stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        5:       act("rnd_min", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        6:       act("rnd_sec", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        7:       act("rnd_min_sec", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        8:       act("rnd_start_stop", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        default: act("rnd_stop_tick", 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
